// File: rtl/io_test_sequencer.sv
// rtl/io_test_sequencer.sv - GPIO pad loopback self-test sequencer (optional IOSEQ_STOP_ON_FAIL_EN)
// Drives each pad high then low, samples it back, and reports pass/fail, error count and first failing pad.
module io_test_sequencer #(
  parameter int NUM_PADS    = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int PAD_W       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count,
  output logic [PAD_W-1:0]    fail_pad,
  input  logic [NUM_PADS-1:0] io_in,
  output logic [NUM_PADS-1:0] io_out,
  output logic [NUM_PADS-1:0] io_oeb
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PAD_W-1:0]    LAST_PAD = PAD_W'(NUM_PADS - 1);
  localparam logic [NUM_PADS-1:0] PAD0     = NUM_PADS'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;

  logic [1:0]       state;
  logic [PAD_W-1:0] pad;
  logic             phase_high;
  logic [CNT_W-1:0] cnt;

  logic             mismatch;
  logic             stop_now;
  logic [7:0]       err_next;
  logic [PAD_W-1:0] next_pad;

  always_comb begin
    mismatch = (io_in[pad] != phase_high);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end
    next_pad = pad + PAD_W'(1);
`ifdef IOSEQ_STOP_ON_FAIL_EN
    stop_now = mismatch;
`else
    stop_now = 1'b0;
`endif
  end

  // Pad drive registers are loaded on the transition into each phase so they stay output-registered.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      pad        <= '0;
      phase_high <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_pad   <= '0;
      io_out     <= '0;
      io_oeb     <= '1;
    end else begin
      case (state)
        IDLE: begin
          io_oeb <= '1;
          io_out <= '0;
          if (start) begin
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_pad   <= '0;
            pad        <= '0;
            phase_high <= 1'b1;
            busy       <= 1'b1;
            cnt        <= CNT_LOAD;
            io_oeb     <= ~PAD0;
            io_out     <= PAD0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && (err_count == 8'd0)) begin
            fail_pad <= pad;
          end
          if (stop_now || (!phase_high && (pad == LAST_PAD))) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_next == 8'd0);
            io_oeb <= '1;
            io_out <= '0;
            state  <= IDLE;
          end else if (phase_high) begin
            phase_high <= 1'b0;
            io_out     <= '0;
            cnt        <= CNT_LOAD;
            state      <= DRIVE;
          end else begin
            pad        <= next_pad;
            phase_high <= 1'b1;
            io_oeb     <= ~(PAD0 << next_pad);
            io_out     <= PAD0 << next_pad;
            cnt        <= CNT_LOAD;
            state      <= DRIVE;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          io_oeb <= '1;
          io_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/io_test_sequencer.md
# io_test_sequencer

Self-test controller for a window of user-project GPIO pads. On `start` it drives each pad in turn as an output, high then low, and reads the level back through the pad's own input path. It reports pass/fail, a saturating error count and the first failing pad index. It sits between the management interface (start/status) and an `io_in`/`io_out`/`io_oeb` slice of the Caravel user IO bank, and owns `io_oeb` for that slice.

## Interface
Parameters:
- `NUM_PADS`, default 8: pads under test; legal range 1..32.
- `HOLD_CYCLES`, default 4: settle cycles per drive phase before sampling; minimum 1.
- `PAD_W`, default `$clog2(NUM_PADS)` (minimum 1): width of `fail_pad`.

Ports:
- `wb_clk_i`, in, 1: single clock.
- `wb_rst_ni`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin test; sampled only in IDLE.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: sticky; last sequence finished; cleared by accepted `start`.
- `pass`, out, 1: valid while `done`=1; 1 = zero mismatches.
- `err_count`, out, 8: mismatch count, saturates at 255.
- `fail_pad`, out, PAD_W: index of the first mismatching pad; valid when `done`=1 and `pass`=0.
- `io_in`, in, NUM_PADS: pad input levels.
- `io_out`, out, NUM_PADS: pad output levels.
- `io_oeb`, out, NUM_PADS: pad output-enable bar; 0 = drive.

## Operation
- States are IDLE, DRIVE, SAMPLE.
- Reset (asynchronous, on `wb_rst_ni`=0):
  - FSM goes to IDLE.
  - `io_oeb` = all 1; `io_out` = 0.
  - `busy`, `done`, `pass`, `err_count`, `fail_pad` = 0.
  - Reset mid-sequence aborts the sequence immediately with the same values.
- IDLE:
  - `io_oeb` = all 1; `io_out` = 0.
  - `start`=1 clears `done`/`pass`/`err_count`/`fail_pad`, sets pad=0, phase=HIGH, `busy`=1, and moves to DRIVE.
- DRIVE:
  - Only pad k is driven: `io_oeb[k]`=0, `io_out[k]` = 1 for phase HIGH, 0 for phase LOW.
  - All other pads: `io_oeb`=1, `io_out`=0.
  - Stays HOLD_CYCLES cycles (down-counter), then moves to SAMPLE.
- SAMPLE (one cycle):
  - Drive held unchanged.
  - Compares `io_in[k]` against the expected phase level.
  - On mismatch: `err_count` increments, saturating at 255. If this is the first mismatch, `fail_pad`=k.
  - Next step:
    - Phase HIGH: go to phase LOW, same pad, DRIVE.
    - Phase LOW with k < NUM_PADS-1: k+1, phase HIGH, DRIVE.
    - Phase LOW with k = NUM_PADS-1: IDLE with `busy`=0, `done`=1, `pass` = (final `err_count`==0), including the mismatch from this cycle.
- `start` while `busy`=1 is ignored.
- `start` asserted continuously re-launches on the first IDLE cycle after completion. `done` then reads 1 for exactly one cycle.
- Pad index and phase do not wrap: the sequence terminates after pad NUM_PADS-1, phase LOW.

## Timing
- `start` is sampled at edge E. `busy`=1 and pad 0 is driven high from E+1.
- Each phase lasts HOLD_CYCLES+1 cycles (DRIVE plus SAMPLE).
- Full run is 2·NUM_PADS·(HOLD_CYCLES+1) cycles of `busy`=1.
- `done`, `pass` and `err_count` are final on the cycle `busy` falls.
- `io_in` is sampled on the rising edge that ends SAMPLE. `io_in` is treated as already synchronous: the pad input path is registered externally.
- Outputs are registered; no combinational path from `io_in` to any output.

## Configuration
- `IOSEQ_STOP_ON_FAIL_EN` defined:
  - The first mismatch in SAMPLE ends the run: next state IDLE, `busy`=0, `done`=1, `pass`=0, `err_count`=1, `fail_pad`=k.
  - All pads return to `io_oeb`=1.
- Not defined: the run always covers every pad and both phases; `err_count` accumulates all mismatches.

## Test plan
All scenarios use NUM_PADS=4, HOLD_CYCLES=2.
- **Ideal loopback** (`io_in`=`io_out` when `io_oeb`=0): pulse `start` → `busy` high 24 cycles; `done`=1, `pass`=1, `err_count`=0; `io_oeb` cycles through 1110, 1101, 1011, 0111, then 1111.
- **Stuck-low pad 2**: `io_in[2]` forced 0 → `pass`=0, `err_count`=1, `fail_pad`=2. With `IOSEQ_STOP_ON_FAIL_EN` defined, `busy` falls after 15 cycles.
- **Pads 1 and 3 stuck high**, macro undefined → `err_count`=2, `fail_pad`=1, run length 24 cycles.
- **Reset mid-run**: `wb_rst_ni` low at cycle 10 of `busy` → same cycle `io_oeb`=1111, `io_out`=0, `busy`/`done`/`err_count`=0; after release, FSM stays IDLE until `start`.
- **Start during busy**: second `start` pulse at cycle 5 → ignored; run still ends at cycle 24. Back-to-back: `start` held high → new run begins the cycle after completion; `err_count` cleared.
- **Saturation** (NUM_PADS=32, all `io_in`=~`io_out`, run repeated without clearing via forced counter preload of 250) → `err_count` stops at 255 and does not wrap.
